booth_control_unit: RTL and testbench

- Sequencing controller for the parameterized Booth/shift-add multiplier datapath.
- Accepts a start request from the host through a ready/start/done handshake.
- Each cycle, drives the datapath strobes (load_words, flush, shift, add, sub) from its status flags (empty, w2_neg, m_is_1, m0).
- Sits directly upstream of the datapath; the pair together forms the complete signed l_word × l_word multiplier.

---
 rtl/booth_control_unit.sv | 95 +++++++++
 tb/tb_booth_control_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_control_unit.sv
// booth_control_unit: IDLE/LOAD/EXEC/DONE sequencer driving the signed Booth/shift-add multiplier datapath.
// Optional early termination on m_is_1 is enabled by defining BOOTH_CTRL_EARLY_EXIT_EN.
module booth_control_unit #(
    parameter int l_word = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_empty,
    input  logic i_w2_neg,
    input  logic i_m_is_1,
    input  logic i_m0,
    output logic o_load_words,
    output logic o_flush,
    output logic o_shift,
    output logic o_add,
    output logic o_sub,
    output logic o_ready,
    output logic o_done
);

    localparam int CW = ($clog2(l_word) > 1) ? $clog2(l_word) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(l_word - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_early;
    logic          w_last;

`ifdef BOOTH_CTRL_EARLY_EXIT_EN
    assign w_early = i_m_is_1;
`else
    assign w_early = i_m_is_1 & 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        o_load_words = 1'b0;
        o_flush      = 1'b0;
        o_shift      = 1'b0;
        o_add        = 1'b0;
        o_sub        = 1'b0;
        o_ready      = 1'b0;
        o_done       = 1'b0;
        // The counter bound caps EXEC at l_word cycles regardless of the flags.
        w_last       = (r_cnt == CNT_LAST) || w_early;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                o_load_words = 1'b1;
                o_flush      = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = i_empty ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                // The multiplier MSB carries negative weight, so it subtracts instead of adds.
                o_add   = i_m0 & ~(w_last & i_w2_neg);
                o_sub   = i_m0 & w_last & i_w2_neg;
                o_shift = ~w_last;
                if (w_last) w_state_nxt = S_DONE;
                else        w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_reset) begin
            o_load_words = 1'b0;
            o_flush      = 1'b0;
            o_shift      = 1'b0;
            o_add        = 1'b0;
            o_sub        = 1'b0;
            o_done       = 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_control_unit.sv
// Self-checking bench for booth_control_unit: a behavioural datapath closes the loop and
// results/latencies are compared against signed arithmetic and the iteration-count rule.
module tb_booth_control_unit;

    localparam int L = 4;

`ifdef BOOTH_CTRL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start;
    logic [L-1:0] word1, word2;
    logic empty, w2_neg, m_is_1, m0;
    logic load_words, flush, shift, add, sub, ready, done;

    int checks = 0;
    int failures = 0;

    // behavioural datapath
    logic [L-1:0]   dp_mplier = '0;
    logic [2*L-1:0] dp_mcand  = '0;
    logic [2*L-1:0] dp_prod   = '0;
    logic           dp_neg    = 1'b0;

    always #5 clk = ~clk;

    booth_control_unit #(.l_word(L)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start),
        .i_empty(empty), .i_w2_neg(w2_neg), .i_m_is_1(m_is_1), .i_m0(m0),
        .o_load_words(load_words), .o_flush(flush), .o_shift(shift),
        .o_add(add), .o_sub(sub), .o_ready(ready), .o_done(done)
    );

    assign empty  = (word1 == '0) || (word2 == '0);
    assign w2_neg = dp_neg;
    assign m_is_1 = (dp_mplier == L'(1));
    assign m0     = dp_mplier[0];

    always @(posedge clk) begin
        if (load_words) begin
            dp_mplier <= word2;
            dp_mcand  <= {{L{word1[L-1]}}, word1};
            dp_neg    <= word2[L-1];
        end
        if (shift) begin
            dp_mplier <= dp_mplier >> 1;
            dp_mcand  <= dp_mcand << 1;
        end
        if (flush)    dp_prod <= '0;
        else if (add) dp_prod <= dp_prod + dp_mcand;
        else if (sub) dp_prod <= dp_prod - dp_mcand;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int strobes();
        return {27'd0, load_words, flush, shift, add, sub};
    endfunction

    // Runs one multiply; expectations come from signed arithmetic and the iteration rule.
    task automatic run_op(input logic [L-1:0] a, input logic [L-1:0] b, input bit hold);
        int n_exp, done_c, adds, subs, shifts, sub_c, viol, dones, p, hi;
        bit neg, emp;
        logic [2*L-1:0] p_exp;
        emp = (a == '0) || (b == '0);
        neg = b[L-1];
        hi = 0;
        for (int i = 0; i < L; i++) if (b[i]) hi = i;
        n_exp = emp ? 0 : ((EARLY && !neg) ? hi + 1 : L);
        p = int'($signed(a)) * int'($signed(b));
        p_exp = p[2*L-1:0];
        done_c = -1; adds = 0; subs = 0; shifts = 0; sub_c = -1; viol = 0; dones = 0;

        @(negedge clk);
        word1 = a; word2 = b; start = 1'b1;
        chk("ready_before_start", int'(ready), 1);
        @(posedge clk);
        for (int c = 1; c <= 2 * L + 6; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 1) begin
                chk("load_strobes", int'(load_words & flush), 1);
            end else if (load_words || flush) viol++;
            if (add && sub) viol++;
            if ((ready || done) && (strobes() != 0)) viol++;
            if (done_c < 0) begin
                if (ready) viol++;
                if (add) adds++;
                if (shift) shifts++;
                if (sub) begin subs++; sub_c = c; end
            end
            if (done) dones++;
            if (done && done_c < 0) begin
                done_c = c;
                chk("product", int'(dp_prod), int'(p_exp));
                start = 1'b0;
            end
            if (done_c > 0 && c == done_c + 1) begin
                chk("ready_after_done", int'(ready), 1);
                chk("idle_no_strobes", strobes(), 0);
                break;
            end
        end
        if (done_c < 0) begin
            chk("done_timeout", 0, 1);
            start = 1'b0;
        end else begin
            chk("done_cycle", done_c, 2 + n_exp);
            chk("add_count", adds, emp ? 0 : ($countones(b) - (neg ? 1 : 0)));
            chk("sub_count", subs, (emp || !neg) ? 0 : 1);
            chk("shift_count", shifts, emp ? 0 : n_exp - 1);
            if (subs > 0) chk("sub_last_exec", sub_c, done_c - 1);
        end
        chk("single_done", dones, 1);
        chk("protocol_viol", viol, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; word1 = '0; word2 = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_ready", int'(ready), 1);
        chk("reset_strobes", strobes() | int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'h3, 4'h5, 1'b0);   // positive x positive
        run_op(4'h3, 4'hE, 1'b0);   // positive x negative
        run_op(4'h8, 4'h8, 1'b0);   // most-negative operands
        run_op(4'h0, 4'h7, 1'b0);   // zero operand
        run_op(4'h7, 4'h0, 1'b0);

        // reset during the second EXEC cycle
        @(negedge clk);
        word1 = 4'h5; word2 = 4'h7; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exec2_active", int'(shift & add), 1);
        rst = 1'b1;
        #1;
        chk("rst_forced_off", strobes() | int'(done), 0);
        @(negedge clk);
        chk("rst_idle_ready", int'(ready), 1);
        chk("rst_idle_strobes", strobes() | int'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(ready), 1);
        chk("post_rst_strobes", strobes() | int'(done), 0);
        run_op(4'h2, 4'h3, 1'b0);

        run_op(4'h5, 4'h5, 1'b1);   // start held while busy

        // start and reset together: reset wins
        @(negedge clk);
        word1 = 4'h3; word2 = 4'h3; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_beats_start", int'(ready), 1);
        chk("rst_beats_start_ld", int'(load_words), 0);
        @(negedge clk);
        chk("rst_beats_start_ld2", int'(load_words), 0);

        for (int i = 0; i < 40; i++)
            run_op(L'($urandom_range(0, 15)), L'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
